// File: rtl/morse_sequencer.sv
// Morse letter transmitter: ROM lookup, MSB-first symbol shifting, trailing gap, Busy/Done handshake.
// Optional MORSE_REPEAT_EN adds a Repeat input that loops the latched letter instead of finishing.
module morse_sequencer #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int TICKS_PER_BIT   = CLOCK_FREQUENCY / 2,
  parameter int PATTERN_WIDTH   = 12,
  parameter int NUM_LETTERS     = 8,
  parameter int GAP_BITS        = 3,
  localparam int LETTER_W       = $clog2(NUM_LETTERS)
) (
  input  logic                ClockIn,
  input  logic                ResetN,
  input  logic                Start,
  input  logic [LETTER_W-1:0] Letter,
`ifdef MORSE_REPEAT_EN
  input  logic                Repeat,
`endif
  output logic                DotDashOut,
  output logic                NewBitOut,
  output logic                Busy,
  output logic                Done
);

  localparam int TW      = $clog2(TICKS_PER_BIT + 1);
  localparam int LW      = $clog2(PATTERN_WIDTH + 1);
  localparam int CNT_MAX = (PATTERN_WIDTH > GAP_BITS) ? PATTERN_WIDTH : GAP_BITS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Raw patterns are right-justified here and left-justified on the way out.
  function automatic logic [PATTERN_WIDTH+LW-1:0] rom(input logic [LETTER_W-1:0] idx);
    logic [31:0] raw;
    int          len;
    case (32'(idx))
      0:       begin raw = 32'b10111;       len = 5;  end
      1:       begin raw = 32'b111010101;   len = 9;  end
      2:       begin raw = 32'b11101011101; len = 11; end
      3:       begin raw = 32'b1110101;     len = 7;  end
      4:       begin raw = 32'b1;           len = 1;  end
      5:       begin raw = 32'b101011101;   len = 9;  end
      6:       begin raw = 32'b111011101;   len = 9;  end
      7:       begin raw = 32'b1010101;     len = 7;  end
      default: begin raw = 32'b0;           len = 0;  end
    endcase
    return {PATTERN_WIDTH'(raw << (PATTERN_WIDTH - len)), LW'(len)};
  endfunction

  state_t                   state_q, state_d;
  logic [PATTERN_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]            bit_q, bit_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic                     done_q, done_d;
  logic [PATTERN_WIDTH-1:0] rom_pat;
  logic [LW-1:0]            rom_len;
  logic                     last_tick;

  assign {rom_pat, rom_len} = rom(Letter);
  assign last_tick          = (tick_q == '0);

`ifdef MORSE_REPEAT_EN
  // Latched copy of the accepted letter so a repeat can reload it.
  logic [PATTERN_WIDTH-1:0] lpat_q;
  logic [LW-1:0]            llen_q;

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      lpat_q <= '0;
      llen_q <= '0;
    end else if (state_q == IDLE && Start) begin
      lpat_q <= rom_pat;
      llen_q <= rom_len;
    end
  end
`endif

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      shreg_q <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          shreg_d = rom_pat;
          tick_d  = TICK_RELOAD;
          if (rom_len != '0) begin
            state_d = SEND;
            bit_d   = CW'(rom_len);
          end else if (GAP_BITS > 0) begin
            state_d = GAP;
            bit_d   = CW'(GAP_BITS);
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (!last_tick) begin
          tick_d = tick_q - 1'b1;
        end else begin
          tick_d  = TICK_RELOAD;
          shreg_d = shreg_q << 1;
          if (bit_q == CW'(1)) begin
            if (GAP_BITS > 0) begin
              state_d = GAP;
              bit_d   = CW'(GAP_BITS);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (!last_tick) begin
          tick_d = tick_q - 1'b1;
        end else begin
          tick_d = TICK_RELOAD;
          if (bit_q != CW'(1)) begin
            bit_d = bit_q - 1'b1;
          end else begin
`ifdef MORSE_REPEAT_EN
            if (Repeat) begin
              shreg_d = lpat_q;
              if (llen_q != '0) begin
                state_d = SEND;
                bit_d   = CW'(llen_q);
              end else begin
                bit_d   = CW'(GAP_BITS);
              end
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy       = (state_q != IDLE);
  assign DotDashOut = (state_q == SEND) && shreg_q[PATTERN_WIDTH-1];
  // The counter sits at its reload value exactly on the first clock of each bit.
  assign NewBitOut  = Busy && (tick_q == TICK_RELOAD);
  assign Done       = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboarded bench for morse_sequencer: a Morse-alphabet model queues the expected
// per-cycle output tuple for each accepted letter; a monitor pops and compares every cycle.
module tb_morse_sequencer;
  localparam int TPB = 4;
  localparam int GAP = 3;

  logic       ClockIn = 1'b0;
  logic       ResetN  = 1'b0;
  logic       Start   = 1'b0;
  logic [2:0] Letter  = '0;
  logic       DotDashOut, NewBitOut, Busy, Done;

  morse_sequencer #(.TICKS_PER_BIT(TPB), .GAP_BITS(GAP)) dut (
    .ClockIn(ClockIn), .ResetN(ResetN), .Start(Start), .Letter(Letter),
    .DotDashOut(DotDashOut), .NewBitOut(NewBitOut), .Busy(Busy), .Done(Done)
  );

  always #5 ClockIn = ~ClockIn;

  typedef struct packed {logic busy; logic dd; logic nb; logic done;} out_t;

  out_t  expq[$];
  int    checks   = 0;
  int    failures = 0;
  int    letters  = 0;
  string morse [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  // Expand a letter from dots and dashes into tone bits, then into per-clock outputs.
  task automatic push_letter(input int l);
    int    bits[$];
    string s;
    s = morse[l];
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) bits.push_back(0);
      if (s[i] == "-") begin bits.push_back(1); bits.push_back(1); bits.push_back(1); end
      else bits.push_back(1);
    end
    for (int g = 0; g < GAP; g++) bits.push_back(0);
    foreach (bits[b])
      for (int k = 0; k < TPB; k++)
        expq.push_back('{busy: 1'b1, dd: bits[b][0], nb: (k == 0), done: 1'b0});
    expq.push_back('{busy: 1'b0, dd: 1'b0, nb: 1'b0, done: 1'b1});
    letters++;
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = '{busy: Busy, dd: DotDashOut, nb: NewBitOut, done: Done};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t busy/dd/nb/done actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected tuple per clock; an empty queue means quiet idle outputs.
  always @(posedge ClockIn) begin
    out_t exp;
    #2;
    exp = (expq.size() > 0) ? expq.pop_front() : out_t'('0);
    check_out("cycle", exp);
  end

  // A Start is accepted only when no letter is still in flight (idle or Done cycle).
  task automatic drive(input logic st, input int l);
    @(negedge ClockIn);
    Start  = st;
    Letter = 3'(l);
    if (st && expq.size() == 0) push_letter(l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  initial begin
    #12;
    check_out("reset_state", out_t'('0));
    @(negedge ClockIn);
    ResetN = 1'b1;
    idle(3);

    drive(1'b1, 0); idle(40);                        // A
    drive(1'b1, 4); idle(20);                        // E
    drive(1'b1, 3); idle(9); drive(1'b1, 5); idle(40); // D with ignored Start
    for (int i = 0; i < 40; i++) drive(1'b1, 4);     // E held: back-to-back
    idle(20);

    for (int i = 0; i < 500; i++)
      drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
    idle(60);

    drive(1'b1, 1); idle(6);
    @(negedge ClockIn);
    ResetN = 1'b0;
    Start  = 1'b0;
    expq.delete();
    #1;
    check_out("reset_abort", out_t'('0));
    idle(2);
    ResetN = 1'b1;
    idle(8);

    checks++;
    if (letters < 10) begin
      failures++;
      $display("FAIL letter_count actual=%0d required>=10", letters);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
